pri_rv32_wb_stage: RTL and testbench

//  Write-back stage directly upstream of the register file. Merges ALU results and
//  in-order load responses onto the register file's single write port.

---
 rtl/pri_rv32_wb_stage.sv | 193 +++++++++++++++++++
 tb/tb_pri_rv32_wb_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pri_rv32_wb_stage.sv
// Write-back stage: merges ALU results and in-order load responses onto the single
// register-file write port, with an outstanding-load queue, an ALU skid entry and a busy scoreboard.
module pri_rv32_wb_stage #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [4:0]               alu_rd_i,
  input  logic [31:0]              alu_data_i,
  input  logic                     ld_valid_i,
  output logic                     ld_ready_o,
  input  logic [4:0]               ld_rd_i,
  input  logic [2:0]               ld_funct3_i,
  input  logic [1:0]               ld_offset_i,
  input  logic                     mem_rvalid_i,
  input  logic [31:0]              mem_rdata_i,
  output logic                     we_o,
  output logic [4:0]               waddr_o,
  output logic [31:0]              wdata_o,
  output logic [31:0]              busy_o,
  output logic [$clog2(DEPTH):0]   ld_count_o,
  output logic                     err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]       q_rd_q  [DEPTH];
  logic [4:0]       q_rd_d  [DEPTH];
  logic [2:0]       q_f3_q  [DEPTH];
  logic [2:0]       q_f3_d  [DEPTH];
  logic [1:0]       q_off_q [DEPTH];
  logic [1:0]       q_off_d [DEPTH];
  logic [DEPTH-1:0] q_v_q, q_v_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic             skid_valid_q, skid_valid_d;
  logic [4:0]       skid_rd_q, skid_rd_d;
  logic [31:0]      skid_data_q, skid_data_d;

  logic             we_q, we_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;

  logic             push, pop, alu_keep;
  logic [4:0]       head_rd;
  logic [2:0]       head_f3;
  logic [1:0]       head_off;
  logic [4:0]       shamt;
  logic [31:0]      shifted;
  logic [31:0]      ld_data;
  logic [31:0]      busy_acc;

  assign alu_ready_o = !skid_valid_q;
  assign ld_ready_o  = (count_q != CW'(DEPTH));
  assign ld_count_o  = count_q;
  assign we_o        = we_q;
  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;
  assign err_o       = err_q;

  assign push     = ld_valid_i && ld_ready_o;
  assign pop      = mem_rvalid_i && (count_q != '0);
  assign alu_keep = alu_valid_i && alu_ready_o && (alu_rd_i != '0);

  assign head_rd  = q_rd_q[rd_ptr_q];
  assign head_f3  = q_f3_q[rd_ptr_q];
  assign head_off = q_off_q[rd_ptr_q];

  always_comb begin
    shamt = '0;
    case (head_f3)
      3'b000, 3'b100: shamt = {head_off, 3'b000};
      3'b001, 3'b101: shamt = {head_off[1], 1'b0, 3'b000};
      default:        shamt = '0;
    endcase
    shifted = mem_rdata_i >> shamt;
    case (head_f3)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_comb begin
    busy_acc = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (q_v_q[i]) busy_acc = busy_acc | (32'd1 << q_rd_q[i]);
    end
    busy_o = {busy_acc[31:1], 1'b0};
  end

  // Push and pop never target the same slot: pop needs a non-empty queue, push a non-full one.
  always_comb begin
    q_rd_d   = q_rd_q;
    q_f3_d   = q_f3_q;
    q_off_d  = q_off_q;
    q_v_d    = q_v_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pop) begin
      q_v_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + AW'(1);
    end
    if (push) begin
      q_rd_d[wr_ptr_q]  = ld_rd_i;
      q_f3_d[wr_ptr_q]  = ld_funct3_i;
      q_off_d[wr_ptr_q] = ld_offset_i;
      q_v_d[wr_ptr_q]   = 1'b1;
      wr_ptr_d          = wr_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Load response beats skid, skid beats a fresh ALU result; a displaced ALU result parks in skid.
  always_comb begin
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    skid_valid_d = skid_valid_q;
    skid_rd_d    = skid_rd_q;
    skid_data_d  = skid_data_q;
    err_d        = err_q || (mem_rvalid_i && (count_q == '0));
    if (pop) begin
      if (head_rd != '0) begin
        we_d    = 1'b1;
        waddr_d = head_rd;
        wdata_d = ld_data;
      end
      if (alu_keep) begin
        skid_valid_d = 1'b1;
        skid_rd_d    = alu_rd_i;
        skid_data_d  = alu_data_i;
      end
    end else if (skid_valid_q) begin
      we_d         = 1'b1;
      waddr_d      = skid_rd_q;
      wdata_d      = skid_data_q;
      skid_valid_d = 1'b0;
    end else if (alu_keep) begin
      we_d    = 1'b1;
      waddr_d = alu_rd_i;
      wdata_d = alu_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      q_v_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_rd_q    <= '0;
      skid_data_q  <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      q_v_q        <= q_v_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      skid_valid_q <= skid_valid_d;
      skid_rd_q    <= skid_rd_d;
      skid_data_q  <= skid_data_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    q_rd_q  <= q_rd_d;
    q_f3_q  <= q_f3_d;
    q_off_q <= q_off_d;
  end

endmodule

// File: tb/tb_pri_rv32_wb_stage.sv
// Directed bench for pri_rv32_wb_stage: expected register writes are queued as stimulus is
// applied and retired in order by a monitor watching the write port.
module tb_pri_rv32_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        alu_valid_i, alu_ready_o;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        ld_valid_i, ld_ready_o;
  logic [4:0]  ld_rd_i;
  logic [2:0]  ld_funct3_i;
  logic [1:0]  ld_offset_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic [31:0] busy_o;
  logic [2:0]  ld_count_o;
  logic        err_o;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  pri_rv32_wb_stage #(.DEPTH(4)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
    .ld_rd_i(ld_rd_i), .ld_funct3_i(ld_funct3_i), .ld_offset_i(ld_offset_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .busy_o(busy_o), .ld_count_o(ld_count_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    alu_valid_i  = 1'b0;
    ld_valid_i   = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
    ld_valid_i  = 1'b1;
    ld_rd_i     = rd;
    ld_funct3_i = f3;
    ld_offset_i = off;
  endtask

  task automatic respond(input logic [31:0] d);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = d;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid_i = 1'b1;
    alu_rd_i    = rd;
    alu_data_i  = d;
  endtask

  // Every write-port pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_we", {31'd0, we_o}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("waddr", {27'd0, waddr_o}, {27'd0, e.addr});
        chk("wdata", wdata_o, e.data);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    alu_rd_i = '0; alu_data_i = '0; ld_rd_i = '0; ld_funct3_i = '0; ld_offset_i = '0;
    mem_rdata_i = '0;
    idle();

    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      alu_valid_i  = 1'($urandom);  alu_rd_i    = 5'($urandom); alu_data_i = $urandom;
      ld_valid_i   = 1'($urandom);  ld_rd_i     = 5'($urandom);
      ld_funct3_i  = 3'($urandom);  ld_offset_i = 2'($urandom);
      mem_rvalid_i = 1'($urandom);  mem_rdata_i = $urandom;
      cyc();
    end
    chk("rst_we",     {31'd0, we_o}, 32'd0);
    chk("rst_waddr",  {27'd0, waddr_o}, 32'd0);
    chk("rst_wdata",  wdata_o, 32'd0);
    chk("rst_err",    {31'd0, err_o}, 32'd0);
    chk("rst_busy",   busy_o, 32'd0);
    chk("rst_count",  {29'd0, ld_count_o}, 32'd0);
    chk("rst_aready", {31'd0, alu_ready_o}, 32'd1);
    chk("rst_lready", {31'd0, ld_ready_o}, 32'd1);
    idle();
    rst_n = 1'b1;
    cyc();

    // ALU only, then the write port holds address/data with we_o low
    alu(5, 32'h12345678); expect_wr(5, 32'h12345678);
    cyc(); idle();
    chk("alu_we", {31'd0, we_o}, 32'd1);
    cyc();
    chk("alu_we_drop", {31'd0, we_o}, 32'd0);
    chk("alu_hold_addr", {27'd0, waddr_o}, 32'd5);
    chk("alu_hold_data", wdata_o, 32'h12345678);

    // ALU to x0 is discarded
    alu(0, 32'hDEADBEEF);
    cyc(); idle(); cyc();

    // load/ALU conflict: load wins, ALU parks in skid
    issue(7, 3'b000, 2'd3);
    cyc(); idle();
    chk("conf_busy", busy_o, 32'h0000_0080);
    respond(32'h80FFFFFF); alu(9, 32'h0000000A);
    expect_wr(7, 32'hFFFFFF80); expect_wr(9, 32'h0000000A);
    cyc(); idle();
    chk("conf_aready0", {31'd0, alu_ready_o}, 32'd0);
    chk("conf_waddr1", {27'd0, waddr_o}, 32'd7);
    cyc();
    chk("conf_aready1", {31'd0, alu_ready_o}, 32'd1);
    chk("conf_waddr2", {27'd0, waddr_o}, 32'd9);
    cyc();

    // load formats
    issue(10, 3'b101, 2'd2); cyc();
    issue(11, 3'b001, 2'd2); cyc();
    issue(12, 3'b010, 2'd0); cyc();
    issue(13, 3'b100, 2'd1); cyc();
    idle();
    chk("fmt_count", {29'd0, ld_count_o}, 32'd4);
    respond(32'hBEEF1234); expect_wr(10, 32'h0000BEEF); cyc();
    respond(32'hBEEF1234); expect_wr(11, 32'hFFFFBEEF); cyc();
    respond(32'hCAFEF00D); expect_wr(12, 32'hCAFEF00D); cyc();
    respond(32'h00008000); expect_wr(13, 32'h00000080); cyc();
    idle(); cyc();

    // load to x0 pops without a write
    issue(0, 3'b010, 2'd0); cyc(); idle();
    chk("x0_busy", busy_o, 32'd0);
    chk("x0_count", {29'd0, ld_count_o}, 32'd1);
    respond(32'h11111111); cyc(); idle();
    chk("x0_we", {31'd0, we_o}, 32'd0);
    chk("x0_popped", {29'd0, ld_count_o}, 32'd0);

    // same-rd push and pop keeps the busy bit
    issue(6, 3'b010, 2'd0); cyc();
    issue(6, 3'b010, 2'd0); respond(32'h00000066); expect_wr(6, 32'h00000066); cyc();
    idle();
    chk("samerd_busy", busy_o, 32'h0000_0040);
    chk("samerd_count", {29'd0, ld_count_o}, 32'd1);
    respond(32'h00000067); expect_wr(6, 32'h00000067); cyc(); idle();
    chk("samerd_clear", busy_o, 32'd0);

    // skid holds while a second load response wins
    issue(14, 3'b010, 2'd0); cyc();
    issue(15, 3'b010, 2'd0); cyc(); idle();
    respond(32'hAAAA0001); alu(16, 32'hBBBB0002);
    expect_wr(14, 32'hAAAA0001); expect_wr(15, 32'hAAAA0003); expect_wr(16, 32'hBBBB0002);
    cyc(); idle();
    respond(32'hAAAA0003); alu(17, 32'hFFFF0000);
    cyc(); idle();
    chk("skid_hold_ready", {31'd0, alu_ready_o}, 32'd0);
    cyc(); cyc();

    // fill the queue
    for (int i = 1; i <= 4; i++) begin
      issue(5'(i), 3'b010, 2'd0); cyc();
    end
    idle();
    chk("full_ready", {31'd0, ld_ready_o}, 32'd0);
    chk("full_busy", busy_o, 32'h0000_001E);
    chk("full_count", {29'd0, ld_count_o}, 32'd4);
    issue(20, 3'b010, 2'd0); respond(32'h00000101); expect_wr(1, 32'h00000101);
    cyc(); idle();
    chk("full_nobypass", {29'd0, ld_count_o}, 32'd3);
    for (int i = 2; i <= 4; i++) begin
      respond(32'h00000100 + 32'(i)); expect_wr(5'(i), 32'h00000100 + 32'(i)); cyc();
    end
    idle();
    chk("drain_busy", busy_o, 32'd0);
    chk("drain_count", {29'd0, ld_count_o}, 32'd0);
    chk("drain_ready", {31'd0, ld_ready_o}, 32'd1);
    cyc();

    // spurious response sets sticky error
    respond(32'h55555555); cyc(); idle();
    chk("spur_we", {31'd0, we_o}, 32'd0);
    chk("spur_err", {31'd0, err_o}, 32'd1);
    cyc(); cyc();
    chk("spur_sticky", {31'd0, err_o}, 32'd1);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("spur_cleared", {31'd0, err_o}, 32'd0);
    cyc(); cyc();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
